// File: rtl/mat_seq.sv
// Control sequencer for the WIDTH x WIDTH systolic matrix unit: weight-load schedule,
// input pacing and result tracking. Optional perf counters enabled by MAT_SEQ_PERF_EN.
module mat_seq #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned LATENCY = 2 * WIDTH,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PROG_W  = $clog2(3 * WIDTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              feed_zero,
    output logic              load_weight,
    output logic [PROG_W-1:0] weight_progress,
    output logic              out_valid,
    output logic              out_last,
    output logic              done,
    output logic [31:0]       perf_busy,
    output logic [31:0]       perf_stall
);

    localparam int unsigned P_LAST = 3 * WIDTH - 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN
    } state_t;

    state_t              state_q;
    logic [PROG_W-1:0]   prog_q;
    logic [CNT_W-1:0]    count_q;
    logic [LATENCY-1:0]  vpipe_q;
    logic [LATENCY-1:0]  lpipe_q;
    logic                done_q;

    logic load_fill;
    logic beat;
    logic comp_beat;
    logic comp_last;

    // Fill phase: rows are taken from the source; afterwards the diagonal sweeps on its own.
    assign load_fill = (state_q == LOAD) && (prog_q < PROG_W'(WIDTH));
    assign in_ready  = load_fill || (state_q == COMPUTE);
    assign beat      = in_valid && in_ready;
    assign comp_beat = (state_q == COMPUTE) && in_valid;
    assign comp_last = comp_beat && (count_q == CNT_W'(1));

    assign cmd_ready       = (state_q == IDLE);
    assign load_weight     = (state_q == LOAD) && (!load_fill || in_valid);
    assign feed_zero       = (((state_q == LOAD) || (state_q == COMPUTE)) && !beat)
                             || (state_q == DRAIN);
    assign weight_progress = prog_q;
    assign out_valid       = vpipe_q[LATENCY-1];
    assign out_last        = lpipe_q[LATENCY-1];
    assign done            = done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            prog_q  <= '0;
            count_q <= '0;
            vpipe_q <= '0;
            lpipe_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            vpipe_q <= (vpipe_q << 1) | LATENCY'(comp_beat);
            lpipe_q <= (lpipe_q << 1) | LATENCY'(comp_last);
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_load) begin
                            state_q <= LOAD;
                            prog_q  <= '0;
                        end else if (cmd_count != '0) begin
                            state_q <= COMPUTE;
                            count_q <= cmd_count;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_weight) begin
                        if (prog_q == PROG_W'(P_LAST)) begin
                            state_q <= IDLE;
                            prog_q  <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            prog_q <= prog_q + PROG_W'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (comp_beat) begin
                        count_q <= count_q - CNT_W'(1);
                        if (comp_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MAT_SEQ_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;

    // Free-running wrap-around counters, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (state_q != IDLE) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (in_ready && !in_valid) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy  = perf_busy_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_busy  = '0;
    assign perf_stall = '0;
`endif

endmodule
